// File: rtl/sw_job_sequencer.sv
// Job dispatcher for the banded Smith-Waterman accelerator.
// Queues R/Q pairs, runs them one at a time with a watchdog, and queues
// aligned results (plus a timeout flag) for the host.
//
// Ports:
//   clk, reset              rising-edge clock, async active-low reset
//   job_valid/job_ready     job push handshake, job_R/job_Q operands
//   acc_start, acc_R/acc_Q  start pulse and held operands to accelerator
//   acc_ready               accelerator done level
//   acc_R/Q_aligned         accelerator results
//   res_valid/res_ready     show-ahead result pop handshake
//   res_R/Q_aligned         head result data, res_timeout head flag
//   busy                    work in flight or queued
//   jobs_done               results written, modulo 256
module sw_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_R,
    input  logic [23:0] job_Q,
    output logic        acc_start,
    output logic [23:0] acc_R,
    output logic [23:0] acc_Q,
    input  logic        acc_ready,
    input  logic [29:0] acc_R_aligned,
    input  logic [29:0] acc_Q_aligned,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [29:0] res_R_aligned,
    output logic [29:0] res_Q_aligned,
    output logic        res_timeout,
    output logic        busy,
    output logic [7:0]  jobs_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t        state_q;
    logic          acc_start_q;
    logic [23:0]   acc_r_q;
    logic [23:0]   acc_qq_q;
    logic [WW-1:0] wdog_q;
    logic          ready_q;
    logic [60:0]   res_ent_q;
    logic [7:0]    done_q;

    logic [23:0]   jr_mem [DEPTH];
    logic [23:0]   jq_mem [DEPTH];
    logic [AW-1:0] jwp_q;
    logic [AW-1:0] jrp_q;
    logic [CW-1:0] jcnt_q;

    // entry = {timeout, R_aligned, Q_aligned}
    logic [60:0]   res_mem [DEPTH];
    logic [AW-1:0] rwp_q;
    logic [AW-1:0] rrp_q;
    logic [CW-1:0] rcnt_q;

    logic job_push;
    logic launch;
    logic res_push;
    logic res_pop;
    logic done;

    assign job_ready = (jcnt_q != FULL);
    assign job_push  = job_valid && job_ready;
    // The result slot is reserved at launch so STORE can never stall.
    assign launch    = (state_q == IDLE) && (jcnt_q != '0) && (rcnt_q != FULL);
    assign res_push  = (state_q == STORE);
    assign res_valid = (rcnt_q != '0);
    assign res_pop   = res_valid && res_ready;
    assign done      = acc_ready && !ready_q;

    assign {res_timeout, res_R_aligned, res_Q_aligned} =
        res_valid ? res_mem[rrp_q] : '0;

    assign acc_start = acc_start_q;
    assign acc_R     = acc_r_q;
    assign acc_Q     = acc_qq_q;
    assign busy      = (state_q != IDLE) || (jcnt_q != '0);
    assign jobs_done = done_q;

    always_ff @(posedge clk) begin
        if (job_push) begin
            jr_mem[jwp_q] <= job_R;
            jq_mem[jwp_q] <= job_Q;
        end
        if (res_push) begin
            res_mem[rwp_q] <= res_ent_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jwp_q  <= '0;
            jrp_q  <= '0;
            jcnt_q <= '0;
            rwp_q  <= '0;
            rrp_q  <= '0;
            rcnt_q <= '0;
        end else begin
            if (job_push) jwp_q <= jwp_q + 1'b1;
            if (launch)   jrp_q <= jrp_q + 1'b1;
            jcnt_q <= jcnt_q + CW'(job_push) - CW'(launch);
            if (res_push) rwp_q <= rwp_q + 1'b1;
            if (res_pop)  rrp_q <= rrp_q + 1'b1;
            rcnt_q <= rcnt_q + CW'(res_push) - CW'(res_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_start_q <= 1'b0;
            acc_r_q     <= '0;
            acc_qq_q    <= '0;
            wdog_q      <= '0;
            ready_q     <= 1'b0;
            res_ent_q   <= '0;
            done_q      <= '0;
        end else begin
            // Tracked in every state, so a level still high from the
            // previous job never looks like a fresh rising edge.
            ready_q <= acc_ready;
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        acc_r_q     <= jr_mem[jrp_q];
                        acc_qq_q    <= jq_mem[jrp_q];
                        acc_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    acc_start_q <= 1'b0;
                    wdog_q      <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        res_ent_q <= {1'b0, acc_R_aligned, acc_Q_aligned};
                        state_q   <= STORE;
                    end else if (wdog_q == WD_MAX) begin
                        res_ent_q <= {1'b1, 60'd0};
                        state_q   <= STORE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                STORE: begin
                    done_q  <= done_q + 8'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_job_sequencer.sv
// Directed bench for sw_job_sequencer with a small accelerator model.
// Instance a uses TIMEOUT=1023, instance b uses TIMEOUT=15.
module tb_sw_job_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        job_valid;
    logic [23:0] job_R;
    logic [23:0] job_Q;
    logic        acc_ready;
    logic [29:0] acc_Ra;
    logic [29:0] acc_Qa;
    logic        res_ready;

    logic        job_ready, acc_start, res_valid, res_timeout, busy;
    logic [23:0] acc_R, acc_Q;
    logic [29:0] res_R, res_Q;
    logic [7:0]  jobs_done;

    logic        b_job_ready, b_acc_start, b_res_valid, b_res_timeout, b_busy;
    logic [23:0] b_acc_R, b_acc_Q;
    logic [29:0] b_res_R, b_res_Q;
    logic [7:0]  b_jobs_done;

    sw_job_sequencer #(.DEPTH(4), .TIMEOUT(1023)) dut_a (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_R(job_R), .job_Q(job_Q),
        .acc_start(acc_start), .acc_R(acc_R), .acc_Q(acc_Q),
        .acc_ready(acc_ready),
        .acc_R_aligned(acc_Ra), .acc_Q_aligned(acc_Qa),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_R_aligned(res_R), .res_Q_aligned(res_Q),
        .res_timeout(res_timeout), .busy(busy), .jobs_done(jobs_done)
    );

    sw_job_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut_b (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(b_job_ready),
        .job_R(job_R), .job_Q(job_Q),
        .acc_start(b_acc_start), .acc_R(b_acc_R), .acc_Q(b_acc_Q),
        .acc_ready(acc_ready),
        .acc_R_aligned(acc_Ra), .acc_Q_aligned(acc_Qa),
        .res_valid(b_res_valid), .res_ready(res_ready),
        .res_R_aligned(b_res_R), .res_Q_aligned(b_res_Q),
        .res_timeout(b_res_timeout), .busy(b_busy), .jobs_done(b_jobs_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    // model mode: 0 = ready after lat cycles, 1 = ready held, 2 = never ready
    int          mode = 0;
    int          lat = 3;
    bit          fix = 1'b0;
    logic [29:0] fixR = '0;
    logic [29:0] fixQ = '0;
    int          starts = 0;

    always @(posedge clk) if (acc_start) starts <= starts + 1;

    initial begin
        int  cnt;
        bit  pend;
        acc_ready = 1'b0;
        acc_Ra = '0;
        acc_Qa = '0;
        cnt = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 2) begin
                acc_ready = 1'b0;
                pend = 1'b0;
            end else if (acc_start) begin
                if (mode == 0) acc_ready = 1'b0;
                pend = (mode == 0);
                cnt = lat;
            end else if (pend) begin
                if (cnt > 1) begin
                    cnt--;
                end else begin
                    pend = 1'b0;
                    acc_ready = 1'b1;
                    acc_Ra = fix ? fixR : {6'h15, acc_R};
                    acc_Qa = fix ? fixQ : {6'h2A, acc_Q};
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] r, input logic [23:0] q);
        job_R = r;
        job_Q = q;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_jd(input logic [7:0] t, input int lim);
        int n;
        n = 0;
        while (jobs_done !== t && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_jobs_done", jobs_done, t);
    endtask

    int          s0, n, unstable, pushed, popped, written, occ;
    logic [7:0]  prev;

    initial begin
        reset = 1'b0;
        job_valid = 1'b0;
        job_R = '0;
        job_Q = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", acc_start, 0);
        chk("rst_accR", acc_R, 0);
        chk("rst_jready", job_ready, 1);
        chk("rst_rvalid", res_valid, 0);
        chk("rst_resR", res_R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jdone", jobs_done, 0);
        reset = 1'b1;
        @(negedge clk);

        // single job
        fix = 1'b1;
        fixR = 30'h12345678;
        fixQ = 30'h0ABCDEF0;
        lat = 40;
        mode = 0;
        s0 = starts;
        push(24'hE4E4E4, 24'h1B1B1B);
        chk("t1_idle_start", acc_start, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_start", acc_start, 1);
        chk("t1_accR", acc_R, 24'hE4E4E4);
        chk("t1_accQ", acc_Q, 24'h1B1B1B);
        unstable = 0;
        n = 0;
        while (!acc_ready && n < 100) begin
            @(negedge clk);
            n++;
            if (acc_R !== 24'hE4E4E4 || acc_Q !== 24'h1B1B1B) unstable++;
        end
        chk("t1_ready_seen", acc_ready, 1);
        chk("t1_stable", unstable, 0);
        chk("t1_no_res_yet", res_valid, 0);
        @(negedge clk);
        chk("t1_store_cycle", res_valid, 0);
        @(negedge clk);
        chk("t1_rvalid", res_valid, 1);
        chk("t1_resR", res_R, 30'h12345678);
        chk("t1_resQ", res_Q, 30'h0ABCDEF0);
        chk("t1_tmo", res_timeout, 0);
        chk("t1_jdone", jobs_done, 1);
        chk("t1_starts", starts - s0, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t1_popped", res_valid, 0);
        chk("t1_idle", busy, 0);
        fix = 1'b0;

        // DEPTH+1 jobs, host does not pop
        do_reset();
        lat = 3;
        s0 = starts;
        for (int i = 0; i < 5; i++)
            push(24'(32'h100 + i), 24'(32'h200 + i));
        chk("t2_jfull", job_ready, 0);
        job_R = 24'hBADBAD;
        job_Q = 24'hBADBAD;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        chk("t2_jfull2", job_ready, 0);
        wait_jd(4, 200);
        repeat (10) @(negedge clk);
        chk("t2_starts4", starts - s0, 4);
        chk("t2_hold_busy", busy, 1);
        chk("t2_hold_start", acc_start, 0);
        chk("t2_rvalid", res_valid, 1);
        chk("t2_jready", job_ready, 1);
        chk("t2_head0", res_R, {6'h15, 24'h000100});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t2_no_launch_yet", acc_start, 0);
        chk("t2_head1", res_R, {6'h15, 24'h000101});
        @(negedge clk);
        chk("t2_launch", acc_start, 1);
        chk("t2_launchR", acc_R, 24'h000104);
        wait_jd(5, 100);
        for (int i = 1; i < 5; i++) begin
            chk("t2_drainR", res_R, {6'h15, 24'(32'h100 + i)});
            chk("t2_drainQ", res_Q, {6'h2A, 24'(32'h200 + i)});
            chk("t2_drainT", res_timeout, 0);
            res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("t2_empty", res_valid, 0);
        chk("t2_busy", busy, 0);
        chk("t2_starts5", starts - s0, 5);

        // stuck-high ready
        do_reset();
        lat = 5;
        push(24'hAAA111, 24'hBBB222);
        wait_jd(1, 100);
        mode = 1;
        chk("t3_ready_high", acc_ready, 1);
        push(24'hCCC333, 24'hDDD444);
        n = 0;
        while (!acc_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t3_start", acc_start, 1);
        repeat (1025) @(negedge clk);
        chk("t3_not_yet", jobs_done, 1);
        @(negedge clk);
        chk("t3_tmo_write", jobs_done, 2);
        chk("t3_headA", res_R, {6'h15, 24'hAAA111});
        chk("t3_headA_t", res_timeout, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t3_headB_R", res_R, 0);
        chk("t3_headB_Q", res_Q, 0);
        chk("t3_headB_t", res_timeout, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t3_empty", res_valid, 0);
        chk("t3_empty_t", res_timeout, 0);

        // no ready, TIMEOUT=15 instance
        mode = 2;
        do_reset();
        push(24'h111111, 24'h222222);
        push(24'h333333, 24'h444444);
        n = 0;
        while (!b_acc_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_start", b_acc_start, 1);
        repeat (17) @(negedge clk);
        chk("t4_not_yet", b_jobs_done, 0);
        chk("t4_not_valid", b_res_valid, 0);
        @(negedge clk);
        chk("t4_written", b_jobs_done, 1);
        chk("t4_rvalid", b_res_valid, 1);
        chk("t4_tmo", b_res_timeout, 1);
        chk("t4_zeroR", b_res_R, 0);
        chk("t4_no_start", b_acc_start, 0);
        @(negedge clk);
        chk("t4_next_start", b_acc_start, 1);
        chk("t4_next_R", b_acc_R, 24'h333333);

        // reset in WAIT
        mode = 0;
        lat = 3;
        do_reset();
        push(24'h5A5A5A, 24'hA5A5A5);
        wait_jd(1, 100);
        mode = 2;
        push(24'h010203, 24'h040506);
        push(24'h070809, 24'h0A0B0C);
        push(24'h0D0E0F, 24'h101112);
        repeat (3) @(negedge clk);
        chk("t5_busy", busy, 1);
        chk("t5_accR", acc_R, 24'h010203);
        chk("t5_rvalid", res_valid, 1);
        #3 reset = 1'b0;
        #1;
        chk("t5_start", acc_start, 0);
        chk("t5_accR0", acc_R, 0);
        chk("t5_accQ0", acc_Q, 0);
        chk("t5_jready", job_ready, 1);
        chk("t5_rvalid0", res_valid, 0);
        chk("t5_resR0", res_R, 0);
        chk("t5_resQ0", res_Q, 0);
        chk("t5_tmo0", res_timeout, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_jdone0", jobs_done, 0);
        @(negedge clk);
        reset = 1'b1;
        s0 = starts;
        repeat (10) @(negedge clk);
        chk("t5_no_start", starts - s0, 0);
        chk("t5_idle", busy, 0);

        // streaming with simultaneous push/pop and jobs_done wrap
        mode = 0;
        lat = 1;
        do_reset();
        pushed = 0;
        popped = 0;
        written = 0;
        prev = jobs_done;
        n = 0;
        while ((written < 256 || popped < 256) && n < 6000) begin
            if (jobs_done !== prev) begin
                written++;
                prev = jobs_done;
            end
            occ = written - popped;
            chk("t6_occ", res_valid, occ != 0);
            job_valid = (pushed < 256);
            job_R = 24'(32'hC00000 + pushed);
            job_Q = 24'(32'h300000 + pushed);
            if (job_valid && job_ready) pushed++;
            res_ready = res_valid && (occ >= 2 || (occ == 1 && n % 3 == 0));
            if (res_ready) begin
                chk("t6_orderR", res_R, {6'h15, 24'(32'hC00000 + popped)});
                chk("t6_orderQ", res_Q, {6'h2A, 24'(32'h300000 + popped)});
                popped++;
            end
            @(negedge clk);
            n++;
        end
        job_valid = 1'b0;
        res_ready = 1'b0;
        chk("t6_written", written, 256);
        chk("t6_popped", popped, 256);
        chk("t6_wrap", jobs_done, 0);
        chk("t6_empty", res_valid, 0);
        chk("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
